// File: rtl/edge_cache_pkg.sv
// Shared types and geometry helpers for the edge-detection row cache.
package edge_cache_pkg;

  typedef enum logic [1:0] {FILL, RUN, DONE} state_t;

  typedef logic [15:0] addr_t;
  typedef logic [31:0] word_t;

  function automatic int calc_wpr(input int width);
    return width / 4;
  endfunction

  function automatic int calc_out_base(input int width, input int height);
    return (width * height) / 4;
  endfunction

endpackage

// File: rtl/edge_row_cache_row_buf.sv
// One image-row buffer: synchronous write port, asynchronous read port.
module row_buf #(
  parameter int DEPTH = 88,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/edge_row_cache.sv
// Three-row line cache: fetches input rows into four rotating buffers, presents
// rows r-1/r/r+1 per word-column and writes accelerator results through to memory.
module edge_row_cache
  import edge_cache_pkg::*;
#(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_do,
  output logic [31:0] mem_di,
  output logic        mem_en,
  output logic        mem_we,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] di,
  output logic [31:0] doa,
  output logic [31:0] dob,
  output logic [31:0] doc,
  output logic        row_cached,
  input  logic        finish
);

  localparam int WPR      = calc_wpr(WIDTH);
  localparam int OUT_BASE = calc_out_base(WIDTH, HEIGHT);
  localparam int CW       = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW       = $clog2(HEIGHT + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(WPR - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  state_t        state;
  logic [RW-1:0] r, frow, crow;
  logic [CW-1:0] col, fcol, pend_col;
  logic [1:0]    pend_buf;
  logic          pend_v;
  logic          armed;

  logic [RW-1:0] r_prev, r_next;
  logic          adv, wr_go, fetch_go, fetch_room, cap_last;
  word_t         buf_q [4];

  // Row k always lives in buffer k mod 4, so the logical map rotates for free
  // and the clamped rows -1 / HEIGHT simply alias rows 0 / HEIGHT-1.
  assign r_prev = (r == '0) ? r : r - 1'b1;
  assign r_next = (r == LAST_ROW) ? r : r + 1'b1;

  // crow counts fully captured rows; captures arrive in ascending order.
  assign row_cached = (state == RUN) && (crow > r_next);
  assign adv        = row_cached && en;
  assign wr_go      = adv && we;
  assign fetch_room = (state == FILL) ? (frow < RW'(2)) : (int'(frow) <= int'(r) + 2);
  // armed keeps the port quiet during reset and the first cycle after release.
  assign fetch_go   = armed && (state != DONE) && !finish && !wr_go &&
                      (frow <= LAST_ROW) && fetch_room;
  assign cap_last   = pend_v && (pend_col == LAST_COL);

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    if (wr_go) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = addr_t'(OUT_BASE + int'(r) * WPR + int'(col));
      mem_di   = di;
    end else if (fetch_go) begin
      mem_en   = 1'b1;
      mem_addr = addr_t'(int'(frow) * WPR + int'(fcol));
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_buf
    row_buf #(.DEPTH(WPR), .AW(CW)) u_buf (
      .clk   (clk),
      .we    (pend_v && (pend_buf == 2'(g))),
      .waddr (pend_col),
      .wdata (mem_do),
      .raddr (col),
      .rdata (buf_q[g])
    );
  end

  assign doa = row_cached ? buf_q[r_prev[1:0]] : '0;
  assign dob = row_cached ? buf_q[r[1:0]]      : '0;
  assign doc = row_cached ? buf_q[r_next[1:0]] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      r        <= '0;
      col      <= '0;
      frow     <= '0;
      fcol     <= '0;
      crow     <= '0;
      pend_v   <= 1'b0;
      pend_buf <= '0;
      pend_col <= '0;
      armed    <= 1'b0;
    end else begin
      armed  <= 1'b1;
      pend_v <= fetch_go;
      if (fetch_go) begin
        pend_buf <= frow[1:0];
        pend_col <= fcol;
        if (fcol == LAST_COL) begin
          fcol <= '0;
          frow <= frow + 1'b1;
        end else begin
          fcol <= fcol + 1'b1;
        end
      end
      if (cap_last) crow <= crow + 1'b1;

      case (state)
        FILL: if (cap_last && (crow == RW'(1))) state <= RUN;
        RUN: begin
          if (adv) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (r == LAST_ROW) state <= DONE;
              else               r <= r + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE:    ;
        default: state <= DONE;
      endcase

      if (finish) state <= DONE;
    end
  end

endmodule

// File: tb/tb_edge_row_cache.sv
// Directed bench for edge_row_cache at WIDTH=16, HEIGHT=4 (WPR=4, OUT_BASE=16).
module tb_edge_row_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic [31:0] mem_do;
  logic [31:0] mem_di;
  logic        mem_en, mem_we;
  logic        en, we, finish;
  logic [31:0] di;
  logic [31:0] doa, dob, doc;
  logic        row_cached;

  int checks   = 0;
  int failures = 0;

  edge_row_cache #(.WIDTH(16), .HEIGHT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_do     (mem_do),
    .mem_di     (mem_di),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .en         (en),
    .we         (we),
    .di         (di),
    .doa        (doa),
    .dob        (dob),
    .doc        (doc),
    .row_cached (row_cached),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  // Memory model: word k holds value k, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_do <= {16'h0000, mem_addr};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rows(input string tag, input int a, input int b, input int c);
    check({tag, "_doa"}, doa, a);
    check({tag, "_dob"}, dob, b);
    check({tag, "_doc"}, doc, c);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; we = 1'b0; di = '0; finish = 1'b0; mem_do = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_di", mem_di, 0);
    check("rst_row_cached", row_cached, 0);
    check_rows("rst", 0, 0, 0);

    // Fill rows 0 and 1; en/we held high must be ignored throughout.
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); en = 1'b1; we = 1'b1; di = 32'hdead; #1;
      check("fill_en", mem_en, 1);
      check("fill_we", mem_we, 0);
      check("fill_addr", mem_addr, k);
      check("fill_rc", row_cached, 0);
    end
    @(negedge clk); #1;
    check("fill_gap_en", mem_en, 0);
    check("fill_gap_rc", row_cached, 0);
    en = 1'b0; we = 1'b0;

    // Row 0: writes interleaved with the prefetch of row 2.
    @(negedge clk); #1;
    check("run_rc", row_cached, 1);
    check_rows("r0c0", 0, 0, 4);
    check("pref_addr8", mem_addr, 8);
    en = 1'b1; we = 1'b1; di = 100; #1;
    check("wr0_we", mem_we, 1);
    check("wr0_addr", mem_addr, 16);
    check("wr0_di", mem_di, 100);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); en = 1'b0; we = 1'b0; #1;
      check("pref_we", mem_we, 0);
      check("pref_addr", mem_addr, 8 + c - 1);
      check("r0_doc_idle", doc, 4 + c);
      @(negedge clk); en = 1'b1; we = 1'b1; di = 100 + c; #1;
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, 16 + c);
      check("wr_di", mem_di, 100 + c);
      check("r0_doc", doc, 4 + c);
    end

    // Row 1 waits for the last word of row 2.
    @(negedge clk); en = 1'b0; we = 1'b0; #1;
    check("r1_wait_rc", row_cached, 0);
    check("r1_wait_doa", doa, 0);
    check("pref_addr11", mem_addr, 11);
    @(negedge clk); #1;
    check("r1_wait2_rc", row_cached, 0);
    check("pref_addr12", mem_addr, 12);
    @(negedge clk); #1;
    check("r1_rc", row_cached, 1);
    check_rows("r1c0", 0, 4, 8);
    check("pref_addr13", mem_addr, 13);
    en = 1'b1;
    @(negedge clk); #1;
    check("pref_addr14", mem_addr, 14);
    check_rows("r1c1", 1, 5, 9);
    @(negedge clk); #1;
    check_rows("r1c2", 2, 6, 10);
    check("pref_addr15_pre", mem_addr, 15);
    we = 1'b1; di = 202; #1;
    check("wr_r1_we", mem_we, 1);
    check("wr_r1_addr", mem_addr, 22);
    check("wr_r1_di", mem_di, 202);
    @(negedge clk); we = 1'b0; #1;
    check("pref_addr15", mem_addr, 15);
    check("pref15_we", mem_we, 0);
    check_rows("r1c3", 3, 7, 11);

    // Row 2 waits for row 3; no further fetches exist.
    @(negedge clk); en = 1'b0; #1;
    check("r2_wait_rc", row_cached, 0);
    check("no_fetch_en", mem_en, 0);
    @(negedge clk); #1;
    check("r2_rc", row_cached, 1);
    check_rows("r2c0", 4, 8, 12);
    en = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); #1;
      check("r2_dob", dob, 8 + c);
    end

    // Bottom row: row r+1 clamps to row 3.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check("r3_rc", row_cached, 1);
      check_rows("r3", 8 + c, 12 + c, 12 + c);
      if (c == 3) begin
        we = 1'b1; di = 303; #1;
        check("wr_r3_we", mem_we, 1);
        check("wr_r3_addr", mem_addr, 31);
        check("wr_r3_di", mem_di, 303);
      end
    end
    @(negedge clk); en = 1'b1; we = 1'b1; di = 1; #1;
    check("done_en", mem_en, 0);
    check("done_rc", row_cached, 0);
    check_rows("done", 0, 0, 0);
    @(negedge clk); #1;
    check("done2_en", mem_en, 0);

    // Second run: refill, then reset in the middle of row 1.
    en = 1'b0; we = 1'b0; rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      check("refill_addr", mem_addr, k);
    end
    @(negedge clk);
    @(negedge clk); #1;
    check("run2_rc", row_cached, 1);
    check_rows("run2_r0c0", 0, 0, 4);
    en = 1'b1;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); #1;
      check("run2_pref", mem_addr, 8 + c);
    end
    @(negedge clk); en = 1'b0; #1;
    check("run2_r1_wait", row_cached, 0);
    @(negedge clk); #1;
    check("run2_r1_rc", row_cached, 1);
    check("run2_r1_dob", dob, 4);
    en = 1'b1;
    @(negedge clk); en = 1'b0; #1;
    check_rows("run2_r1c1", 1, 5, 9);
    rst = 1'b0; #1;
    check("midrst_rc", row_cached, 0);
    check_rows("midrst", 0, 0, 0);
    check("midrst_en", mem_en, 0);
    check("midrst_addr", mem_addr, 0);

    // Third run: refill from address 0, then finish with a same-cycle write.
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      check("refill3_addr", mem_addr, k);
    end
    @(negedge clk);
    @(negedge clk); #1;
    check("run3_rc", row_cached, 1);
    check_rows("run3_r0c0", 0, 0, 4);
    finish = 1'b1; en = 1'b1; we = 1'b1; di = 555; #1;
    check("fin_wr_we", mem_we, 1);
    check("fin_wr_addr", mem_addr, 16);
    check("fin_wr_di", mem_di, 555);
    @(negedge clk); finish = 1'b0; #1;
    check("fin_en", mem_en, 0);
    check("fin_rc", row_cached, 0);
    check("fin_dob", dob, 0);
    @(negedge clk); #1;
    check("fin2_en", mem_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
